mc_main_control: RTL and testbench

- Multi-cycle main control FSM for the 32-bit MIPS processor.
- Sequences fetch, decode, execute, memory and writeback for one instruction at a time.
- Drives the 3-bit ALUop consumed by the ALU control decoder, plus datapath mux selects and register/PC enables.
- Runs a valid/ready handshake with the unified instruction/data memory.

---
 rtl/mc_main_control.sv | 216 +++++++++++++++++++++
 tb/tb_mc_main_control.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mc_main_control.sv
// Multi-cycle MIPS main control FSM: fetch/decode/execute/memory/writeback sequencing.
// Optional INSTR_COUNT_EN macro adds a retired-instruction counter output.
//
// state    | meaning
// FETCH    | read instruction, PC += 4, wait for mem_ready
// DECODE   | branch target into ALUOut, latch opcode, dispatch
// EXEC_R   | R-type ALU operation
// EXEC_I   | immediate ALU operation
// MEM_ADDR | effective address computation
// MEM_RD   | load access, wait for mem_ready
// MEM_WR   | store access, wait for mem_ready
// WB_R     | write rd from ALUOut
// WB_I     | write rt from ALUOut
// WB_MEM   | write rt from MDR
// BRANCH   | compare and conditional PC load
// JUMP     | PC <- jump target
// HALT     | illegal opcode trap, left only by reset
module mc_main_control #(
    parameter int STATE_W = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_byte,
    output logic [2:0] alu_op,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       ir_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       halted
`ifdef INSTR_COUNT_EN
    ,
    output logic [31:0] retired_count
`endif
);

    typedef enum logic [STATE_W-1:0] {
        FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR,
        WB_R, WB_I, WB_MEM, BRANCH, JUMP, HALT
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SUBI = 6'b001001;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_LB   = 6'b100000;
    localparam logic [5:0] OP_SB   = 6'b101000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t     state_q, state_d;
    logic [5:0] op_q, op_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FETCH;
            op_q    <= 6'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_byte   = 1'b0;
        alu_op     = 3'b000;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        halted     = 1'b0;
        case (state_q)
            FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                alu_op    = 3'b101;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = DECODE;
                end
            end
            DECODE: begin
                alu_src_b = 2'b11;
                alu_op    = 3'b101;
                op_d      = opcode;
                case (opcode)
                    OP_R:                                         state_d = EXEC_R;
                    OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_SLTI:   state_d = EXEC_I;
                    OP_LW, OP_SW, OP_LB, OP_SB:                   state_d = MEM_ADDR;
                    OP_BEQ, OP_BNE:                               state_d = BRANCH;
                    OP_J:                                         state_d = JUMP;
                    default:                                      state_d = HALT;
                endcase
            end
            EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = 3'b111;
                state_d   = WB_R;
            end
            EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                case (op_q)
                    OP_SUBI: alu_op = 3'b110;
                    OP_ANDI: alu_op = 3'b000;
                    OP_ORI:  alu_op = 3'b001;
                    OP_SLTI: alu_op = 3'b100;
                    default: alu_op = 3'b101;
                endcase
                state_d = WB_I;
            end
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 3'b101;
                state_d   = (op_q == OP_SW || op_q == OP_SB) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                mem_req  = 1'b1;
                mem_byte = (op_q == OP_LB);
                if (mem_ready) state_d = WB_MEM;
            end
            MEM_WR: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_byte = (op_q == OP_SB);
                if (mem_ready) state_d = FETCH;
            end
            WB_R: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = FETCH;
            end
            WB_I: begin
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = FETCH;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 3'b110;
                pc_src    = 2'b01;
                pc_write  = (op_q == OP_BEQ) ? alu_zero : ~alu_zero;
                state_d   = FETCH;
            end
            JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
                state_d  = FETCH;
            end
            HALT: begin
                halted  = 1'b1;
                state_d = HALT;
            end
            default: state_d = FETCH;
        endcase
        // Reset holds every output quiet, aborting any in-flight access immediately.
        if (!rst_n) begin
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            mem_byte   = 1'b0;
            alu_op     = 3'b000;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b00;
            pc_write   = 1'b0;
            pc_src     = 2'b00;
            ir_write   = 1'b0;
            reg_write  = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            halted     = 1'b0;
        end
    end

`ifdef INSTR_COUNT_EN
    logic [31:0] retired_q;

    // Every non-FETCH state that can enter FETCH is a retiring state; HALT never does.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retired_q <= 32'd0;
        end else if (state_d == FETCH && state_q != FETCH) begin
            retired_q <= retired_q + 32'd1;
        end
    end

    assign retired_count = retired_q;
`endif

endmodule

// File: tb/tb_mc_main_control.sv
// Scoreboard bench for mc_main_control: stimulus queues expected output bundles, monitor compares.
module tb_mc_main_control;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'b0;
    logic       alu_zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, mem_byte;
    logic [2:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write, reg_write, reg_dst, mem_to_reg, halted;
`ifdef INSTR_COUNT_EN
    logic [31:0] retired_count;
`endif

    mc_main_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .alu_zero(alu_zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .mem_byte(mem_byte), .alu_op(alu_op), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .pc_write(pc_write), .pc_src(pc_src),
        .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .halted(halted)
`ifdef INSTR_COUNT_EN
        , .retired_count(retired_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [16:0] v;
        string       name;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        cur;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [16:0] got;

    assign got = {mem_req, mem_we, mem_byte, alu_op, alu_src_a, alu_src_b,
                  pc_write, pc_src, ir_write, reg_write, reg_dst, mem_to_reg, halted};

    function automatic logic [16:0] ev(input logic req, we, byt, input logic [2:0] aop,
                                       input logic sa, input logic [1:0] sbs, input logic pcw,
                                       input logic [1:0] pcs, input logic irw, rw, rd, m2r, hlt);
        return {req, we, byt, aop, sa, sbs, pcw, pcs, irw, rw, rd, m2r, hlt};
    endfunction

    function automatic logic [16:0] e_fetch(input logic rdy);
        return ev(1, 0, 0, 3'b101, 0, 2'b01, rdy, 2'b00, rdy, 0, 0, 0, 0);
    endfunction
    function automatic logic [16:0] e_exi(input logic [2:0] aop);
        return ev(0, 0, 0, aop, 1, 2'b10, 0, 2'b00, 0, 0, 0, 0, 0);
    endfunction
    function automatic logic [16:0] e_mem(input logic we, input logic byt);
        return ev(1, we, byt, 3'b000, 0, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0);
    endfunction
    function automatic logic [16:0] e_br(input logic pcw);
        return ev(0, 0, 0, 3'b110, 1, 2'b00, pcw, 2'b01, 0, 0, 0, 0, 0);
    endfunction

    localparam logic [16:0] E_ZERO  = 17'h0;
    localparam logic [16:0] E_DEC   = {3'b000, 3'b101, 1'b0, 2'b11, 1'b0, 2'b00, 5'b00000};
    localparam logic [16:0] E_EXR   = {3'b000, 3'b111, 1'b1, 2'b00, 1'b0, 2'b00, 5'b00000};
    localparam logic [16:0] E_MADDR = {3'b000, 3'b101, 1'b1, 2'b10, 1'b0, 2'b00, 5'b00000};
    localparam logic [16:0] E_WBR   = {3'b000, 3'b000, 1'b0, 2'b00, 1'b0, 2'b00, 5'b01100};
    localparam logic [16:0] E_WBI   = {3'b000, 3'b000, 1'b0, 2'b00, 1'b0, 2'b00, 5'b01000};
    localparam logic [16:0] E_WBM   = {3'b000, 3'b000, 1'b0, 2'b00, 1'b0, 2'b00, 5'b01010};
    localparam logic [16:0] E_JMP   = {3'b000, 3'b000, 1'b0, 2'b00, 1'b1, 2'b10, 5'b00000};
    localparam logic [16:0] E_HALT  = 17'h00001;

    // One clock cycle: drive inputs, queue the outputs expected during this cycle.
    task automatic cyc(input logic r, input logic rdy, input logic z, input logic [5:0] op,
                       input logic [16:0] e, input string nm);
        exp_t x;
        rst_n     = r;
        mem_ready = rdy;
        alu_zero  = z;
        opcode    = op;
        x.v       = e;
        x.name    = nm;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic itype(input logic [5:0] op, input logic [2:0] aop, input string nm);
        cyc(1, 1, 0, op, e_fetch(1), {nm, "_fetch"});
        cyc(1, 0, 0, op, E_DEC, {nm, "_decode"});
        cyc(1, 0, 0, op, e_exi(aop), {nm, "_exec_i"});
        cyc(1, 0, 0, op, E_WBI, {nm, "_wb_i"});
    endtask

    task automatic branch(input logic [5:0] op, input logic z, input logic pcw, input string nm);
        cyc(1, 1, z, op, e_fetch(1), {nm, "_fetch"});
        cyc(1, 0, z, op, E_DEC, {nm, "_decode"});
        cyc(1, 0, z, op, e_br(pcw), {nm, "_branch"});
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            cur = sb_q.pop_front();
            n_cmp++;
            if (got !== cur.v) begin
                n_bad++;
                $display("FAIL %s: got %05h expected %05h", cur.name, got, cur.v);
            end
        end
    end

    initial begin
        @(posedge clk);
        #1;
        cyc(0, 0, 0, 6'b000000, E_ZERO, "reset_0");
        cyc(0, 1, 0, 6'b000000, E_ZERO, "reset_1");

        // R-type with mem_ready held high throughout (ignored outside memory states)
        cyc(1, 1, 0, 6'b000000, e_fetch(1), "r_fetch");
        cyc(1, 1, 0, 6'b000000, E_DEC, "r_decode");
        cyc(1, 1, 0, 6'b000000, E_EXR, "r_exec");
        cyc(1, 1, 0, 6'b000000, E_WBR, "r_wb");

        // lw with 3 wait states; opcode input changes after decode and must be ignored
        cyc(1, 1, 0, 6'b100011, e_fetch(1), "lw_fetch");
        cyc(1, 0, 0, 6'b100011, E_DEC, "lw_decode");
        cyc(1, 0, 0, 6'b000000, E_MADDR, "lw_maddr");
        cyc(1, 0, 0, 6'b101011, e_mem(0, 0), "lw_wait1");
        cyc(1, 0, 0, 6'b101011, e_mem(0, 0), "lw_wait2");
        cyc(1, 0, 0, 6'b101011, e_mem(0, 0), "lw_wait3");
        cyc(1, 1, 0, 6'b101011, e_mem(0, 0), "lw_rd_done");
        cyc(1, 0, 0, 6'b101011, E_WBM, "lw_wb_mem");

        // fetch with one wait state, then branches
        cyc(1, 0, 1, 6'b000100, e_fetch(0), "beq_fetch_wait");
        branch(6'b000100, 1, 1, "beq_z1");
        branch(6'b000101, 1, 0, "bne_z1");
        branch(6'b000100, 0, 0, "beq_z0");
        branch(6'b000101, 0, 1, "bne_z0");

        itype(6'b001000, 3'b101, "addi");
        itype(6'b001001, 3'b110, "subi");
        itype(6'b001100, 3'b000, "andi");
        itype(6'b001101, 3'b001, "ori");
        itype(6'b001010, 3'b100, "slti");

        // sb with one wait state, lb zero-wait
        cyc(1, 1, 0, 6'b101000, e_fetch(1), "sb_fetch");
        cyc(1, 0, 0, 6'b101000, E_DEC, "sb_decode");
        cyc(1, 0, 0, 6'b101000, E_MADDR, "sb_maddr");
        cyc(1, 0, 0, 6'b101000, e_mem(1, 1), "sb_wait");
        cyc(1, 1, 0, 6'b101000, e_mem(1, 1), "sb_wr_done");
        cyc(1, 1, 0, 6'b100000, e_fetch(1), "lb_fetch");
        cyc(1, 1, 0, 6'b100000, E_DEC, "lb_decode");
        cyc(1, 1, 0, 6'b100000, E_MADDR, "lb_maddr");
        cyc(1, 1, 0, 6'b100000, e_mem(0, 1), "lb_rd");
        cyc(1, 1, 0, 6'b100000, E_WBM, "lb_wb_mem");

        cyc(1, 1, 0, 6'b000010, e_fetch(1), "j_fetch");
        cyc(1, 1, 0, 6'b000010, E_DEC, "j_decode");
        cyc(1, 1, 0, 6'b000010, E_JMP, "j_jump");

        // reset during a stalled store aborts the access
        cyc(1, 1, 0, 6'b101011, e_fetch(1), "swr_fetch");
        cyc(1, 0, 0, 6'b101011, E_DEC, "swr_decode");
        cyc(1, 0, 0, 6'b101011, E_MADDR, "swr_maddr");
        cyc(1, 0, 0, 6'b101011, e_mem(1, 0), "swr_wait");
        cyc(0, 0, 0, 6'b101011, E_ZERO, "swr_reset_0");
        cyc(0, 1, 0, 6'b101011, E_ZERO, "swr_reset_1");
        cyc(1, 0, 0, 6'b101011, e_fetch(0), "swr_refetch");

        // illegal opcode traps until reset
        cyc(1, 1, 0, 6'b111111, e_fetch(1), "ill_fetch");
        cyc(1, 1, 0, 6'b111111, E_DEC, "ill_decode");
        for (int i = 0; i < 12; i++) begin
            cyc(1, i[0], i[1], 6'b000000, E_HALT, $sformatf("halt_%0d", i));
        end
        cyc(0, 1, 0, 6'b000000, E_ZERO, "halt_reset");
        cyc(1, 1, 0, 6'b000000, e_fetch(1), "post_halt_fetch");
        cyc(1, 1, 0, 6'b000000, E_DEC, "post_halt_decode");
        cyc(1, 1, 0, 6'b000000, E_EXR, "post_halt_exec");
        cyc(1, 1, 0, 6'b000000, E_WBR, "post_halt_wb");

`ifdef INSTR_COUNT_EN
        cyc(0, 0, 0, 6'b000000, E_ZERO, "cnt_reset");
        cyc(1, 1, 0, 6'b000000, e_fetch(1), "cnt_r_fetch");
        cyc(1, 1, 0, 6'b000000, E_DEC, "cnt_r_decode");
        cyc(1, 1, 0, 6'b000000, E_EXR, "cnt_r_exec");
        cyc(1, 1, 0, 6'b000000, E_WBR, "cnt_r_wb");
        cyc(1, 1, 0, 6'b101011, e_fetch(1), "cnt_sw_fetch");
        cyc(1, 1, 0, 6'b101011, E_DEC, "cnt_sw_decode");
        cyc(1, 1, 0, 6'b101011, E_MADDR, "cnt_sw_maddr");
        cyc(1, 1, 0, 6'b101011, e_mem(1, 0), "cnt_sw_wr");
        cyc(1, 1, 0, 6'b000010, e_fetch(1), "cnt_j_fetch");
        cyc(1, 1, 0, 6'b000010, E_DEC, "cnt_j_decode");
        cyc(1, 1, 0, 6'b000010, E_JMP, "cnt_j_jump");
        n_cmp++;
        if (retired_count !== 32'd3) begin
            n_bad++;
            $display("FAIL retired_count: got %0d expected 3", retired_count);
        end
`endif

        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
